// File: rtl/alu_issue_queue.sv
// ALU issue stage: circular request FIFO feeding the combinational ALU, followed by a
// registered result stage with its own valid/ready handshake and a sticky overflow flag.
module alu_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [2:0]            in_ALUop,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_ALUop,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_Overflow,
    input  logic                  alu_CarryOut,
    input  logic                  alu_Zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_Result,
    output logic [2:0]            out_flags,
    output logic [ADDR_W:0]       count,
    output logic                  sticky_ovf,
    input  logic                  clr_sticky
);

    localparam int              ENTRY_W = 2 * DATA_WIDTH + 3;
    localparam logic [ADDR_W:0] FULL    = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic               push;
    logic               pop;
    logic               not_empty;
    logic [ENTRY_W-1:0] head;

    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL);
    assign push      = in_valid & in_ready;
    assign pop       = not_empty & (~out_valid | out_ready);
    assign head      = mem[rd_ptr];

    always_comb begin
        alu_A     = '0;
        alu_B     = '0;
        alu_ALUop = '0;
        if (not_empty) begin
            alu_A     = head[ENTRY_W-1 -: DATA_WIDTH];
            alu_B     = head[DATA_WIDTH+2 -: DATA_WIDTH];
            alu_ALUop = head[2:0];
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_A, in_B, in_ALUop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_Result <= '0;
            out_flags  <= '0;
        end else if (pop) begin
            out_valid  <= 1'b1;
            out_Result <= alu_Result;
            out_flags  <= {alu_Overflow, alu_CarryOut, alu_Zero};
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A capture carrying overflow beats a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (pop && alu_Overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue; a behavioural ALU closes the loop
// between alu_* outputs and alu_* inputs.
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_ALUop;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_ALUop;
    logic [31:0] alu_Result;
    logic        alu_Overflow;
    logic        alu_CarryOut;
    logic        alu_Zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Result;
    logic [2:0]  out_flags;
    logic [2:0]  count;
    logic        sticky_ovf;
    logic        clr_sticky;

    int checks   = 0;
    int failures = 0;

    alu_issue_queue #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
        .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
        .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_Result(out_Result), .out_flags(out_flags),
        .count(count), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    // Carry reports a borrow on the subtracting ops.
    always_comb begin
        logic [32:0] sum;
        logic [32:0] dif;
        sum          = {1'b0, alu_A} + {1'b0, alu_B};
        dif          = {1'b0, alu_A} - {1'b0, alu_B};
        alu_Result   = '0;
        alu_Overflow = 1'b0;
        alu_CarryOut = 1'b0;
        case (alu_ALUop)
            3'b000: alu_Result = alu_A & alu_B;
            3'b001: alu_Result = alu_A | alu_B;
            3'b010: begin
                alu_Result   = sum[31:0];
                alu_CarryOut = sum[32];
                alu_Overflow = (alu_A[31] == alu_B[31]) && (sum[31] != alu_A[31]);
            end
            3'b011: begin
                alu_Result   = {31'd0, dif[32]};
                alu_CarryOut = dif[32];
            end
            3'b100: alu_Result = alu_A ^ alu_B;
            3'b101: alu_Result = ~(alu_A | alu_B);
            3'b110: begin
                alu_Result   = dif[31:0];
                alu_CarryOut = dif[32];
                alu_Overflow = (alu_A[31] != alu_B[31]) && (dif[31] != alu_A[31]);
            end
            default: begin
                alu_Result   = {31'd0, ($signed(alu_A) < $signed(alu_B))};
                alu_CarryOut = dif[32];
            end
        endcase
        alu_Zero = (alu_Result == 32'd0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
        in_valid = v;
        in_A     = a;
        in_B     = b;
        in_ALUop = op;
        step();
    endtask

    initial begin
        logic [31:0] exp_q[$];
        int          pushed;
        int          got;
        int          cyc;
        logic        count_ok;

        rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_ALUop = '0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        #12;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_result", out_Result, 32'd0);
        checkOutput("rst_out_flags", 32'(out_flags), 32'd0);
        checkOutput("rst_sticky", 32'(sticky_ovf), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("empty_alu_a", alu_A, 32'd0);

        // Single overflowing ADD: visible one edge after acceptance.
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
        checkOutput("add_count_after_push", 32'(count), 32'd1);
        checkOutput("add_no_bypass", 32'(out_valid), 32'd0);
        checkOutput("add_alu_a", alu_A, 32'h7FFF_FFFF);
        applyStimulus(1'b0, '0, '0, 3'b000);
        checkOutput("add_out_valid", 32'(out_valid), 32'd1);
        checkOutput("add_result", out_Result, 32'h8000_0000);
        checkOutput("add_flags", 32'(out_flags), 32'b100);
        checkOutput("add_sticky", 32'(sticky_ovf), 32'd1);
        checkOutput("add_count_after_pop", 32'(count), 32'd0);
        out_ready = 1'b1;
        step();
        checkOutput("add_drained", 32'(out_valid), 32'd0);

        // Back-to-back throughput.
        applyStimulus(1'b1, 32'd5, 32'd5, 3'b110);
        checkOutput("b2b_count0", 32'(count), 32'd1);
        applyStimulus(1'b1, 32'd1, 32'd2, 3'b011);
        checkOutput("b2b_res0", out_Result, 32'h0);
        checkOutput("b2b_flags0", 32'(out_flags), 32'b001);
        checkOutput("b2b_count1", 32'(count), 32'd1);
        applyStimulus(1'b1, 32'd0, 32'd0, 3'b101);
        checkOutput("b2b_res1", out_Result, 32'h1);
        checkOutput("b2b_flags1", 32'(out_flags), 32'b010);
        checkOutput("b2b_count2", 32'(count), 32'd1);
        applyStimulus(1'b0, '0, '0, 3'b000);
        checkOutput("b2b_valid2", 32'(out_valid), 32'd1);
        checkOutput("b2b_res2", out_Result, 32'hFFFF_FFFF);
        checkOutput("b2b_flags2", 32'(out_flags), 32'b000);
        checkOutput("b2b_count3", 32'(count), 32'd0);
        step();

        // Fill under backpressure: request i is ADD (i+10)+i.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'(i + 10), 32'(i), 3'b010);
        end
        in_valid = 1'b0;
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fill_held_result", out_Result, 32'd10);
        checkOutput("fill_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        checkOutput("fill_in_ready_rise", 32'(in_ready), 32'd1);
        checkOutput("fill_count_after_pop", 32'(count), 32'd3);
        for (int i = 1; i < 5; i++) begin
            checkOutput($sformatf("fill_order%0d", i), out_Result, 32'(2 * i + 10));
            step();
        end
        checkOutput("fill_done_valid", 32'(out_valid), 32'd0);

        // Wrap-around: ten XORs with out_ready toggling, checked against a queue.
        pushed = 0;
        got    = 0;
        cyc    = 0;
        while ((got < 10) && (cyc < 80)) begin
            in_valid  = (pushed < 10);
            in_A      = 32'h1111_1111 * 32'(pushed + 1);
            in_B      = 32'h0F0F_0F0F;
            in_ALUop  = 3'b100;
            out_ready = (cyc % 3) != 1;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("wrap_order%0d", got), out_Result, exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_A ^ in_B);
                pushed++;
            end
            step();
            cyc++;
        end
        checkOutput("wrap_all_received", 32'(got), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("wrap_count_zero", 32'(count), 32'd0);
        checkOutput("wrap_alu_a_zero", alu_A, 32'd0);
        checkOutput("wrap_alu_b_zero", alu_B, 32'd0);

        // Asynchronous reset with queued and registered results.
        out_ready = 1'b0;
        applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b010);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(i), 32'd1, 3'b010);
        end
        in_valid = 1'b0;
        checkOutput("prerst_count", 32'(count), 32'd3);
        checkOutput("prerst_sticky", 32'(sticky_ovf), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_out_result", out_Result, 32'd0);
        checkOutput("arst_sticky", 32'(sticky_ovf), 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        count_ok  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid || (count != 3'd0)) count_ok = 1'b0;
        end
        checkOutput("arst_no_stale", 32'(count_ok), 32'd1);

        // Overflow capture races a clear; the set must win.
        applyStimulus(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b010);
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        step();
        checkOutput("race_flags", 32'(out_flags), 32'b111);
        checkOutput("race_sticky", 32'(sticky_ovf), 32'd1);
        step();
        clr_sticky = 1'b0;
        checkOutput("clear_sticky", 32'(sticky_ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
